// File: rtl/mux_pkg.sv
`default_nettype none
// +-----------------------------------------------------------------+
// | mux_pkg: shared arbiter state encoding and select-width helper  |
// | Revision: 1.0                                                   |
// +-----------------------------------------------------------------+
package mux_pkg;

  typedef enum logic [0:0] {
    IDLE   = 1'b0,
    LOCKED = 1'b1
  } arb_state_t;

  // Select width never collapses to zero, even for a degenerate count.
  function automatic int sel_w(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage
`default_nettype wire

// File: rtl/mux_rr_pick.sv
`default_nettype none
// +-----------------------------------------------------------------+
// | mux_rr_pick: combinational rotating-priority encoder            |
// | Revision: 1.0                                                   |
// +-----------------------------------------------------------------+
module mux_rr_pick #(
  parameter int N     = 4,
  parameter int SEL_W = 2
) (
  input  logic [N-1:0]     req,
  input  logic [SEL_W-1:0] ptr,
  output logic             any,
  output logic [SEL_W-1:0] winner
);

  // Walk from the farthest offset back to ptr so the nearest request wins last.
  always_comb begin
    int idx;
    idx    = 0;
    any    = 1'b0;
    winner = '0;
    for (int i = N - 1; i >= 0; i--) begin
      idx = (int'(ptr) + i) % N;
      if (req[idx]) begin
        any    = 1'b1;
        winner = SEL_W'(idx);
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/mux_arbiter.sv
`default_nettype none
// +-----------------------------------------------------------------+
// | mux_arbiter: packet-aware round-robin arbiter with registered   |
// | one-deep output stage and lock timeout                          |
// | Revision: 1.0                                                   |
// +-----------------------------------------------------------------+
module mux_arbiter
  import mux_pkg::*;
#(
  parameter int WIDTH    = 8,
  parameter int N_STATES = 4,
  parameter int TIMEOUT  = 16,
  localparam int SEL_W   = mux_pkg::sel_w(N_STATES)
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [WIDTH-1:0]    i_x [N_STATES],
  input  logic [N_STATES-1:0] i_valid,
  input  logic [N_STATES-1:0] i_last,
  output logic [N_STATES-1:0] o_ready,
  output logic [WIDTH-1:0]    o_x,
  output logic                o_valid,
  output logic                o_last,
  output logic [SEL_W-1:0]    o_src,
  input  logic                i_ready,
  output logic                o_timeout
);

  localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  arb_state_t       state;
  logic [SEL_W-1:0] owner;
  logic [SEL_W-1:0] ptr;
  logic [CNT_W-1:0] idle_cnt;

  logic             space;
  logic             pick_any;
  logic [SEL_W-1:0] pick_idx;
  logic [SEL_W-1:0] sel;
  logic             req_ok;
  logic             accept;
  logic             timeout_hit;

  function automatic logic [SEL_W-1:0] wrap_inc(input logic [SEL_W-1:0] v);
    if (int'(v) == N_STATES - 1) return '0;
    return v + 1'b1;
  endfunction

  mux_rr_pick #(
    .N     (N_STATES),
    .SEL_W (SEL_W)
  ) u_pick (
    .req    (i_valid),
    .ptr    (ptr),
    .any    (pick_any),
    .winner (pick_idx)
  );

  // While locked, only the owner is eligible regardless of other requests.
  always_comb begin
    space       = !o_valid || i_ready;
    sel         = (state == LOCKED) ? owner : pick_idx;
    req_ok      = (state == LOCKED) ? i_valid[owner] : pick_any;
    accept      = space && req_ok;
    timeout_hit = (TIMEOUT > 0) && (state == LOCKED) && !i_valid[owner] &&
                  (idle_cnt == CNT_W'(TIMEOUT - 1));
    o_ready     = '0;
    if (accept) o_ready[sel] = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      owner     <= '0;
      ptr       <= '0;
      idle_cnt  <= '0;
      o_timeout <= 1'b0;
    end else begin
      o_timeout <= 1'b0;
      case (state)
        IDLE: begin
          idle_cnt <= '0;
          if (accept) begin
            if (i_last[sel]) begin
              ptr <= wrap_inc(sel);
            end else begin
              state <= LOCKED;
              owner <= sel;
            end
          end
        end
        LOCKED: begin
          if (i_valid[owner]) begin
            idle_cnt <= '0;
            if (accept && i_last[owner]) begin
              state <= IDLE;
              ptr   <= wrap_inc(owner);
            end
          end else if (timeout_hit) begin
            state     <= IDLE;
            ptr       <= wrap_inc(owner);
            idle_cnt  <= '0;
            o_timeout <= 1'b1;
          end else if (TIMEOUT > 0) begin
            idle_cnt <= idle_cnt + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Drain and reload in the same cycle keeps one beat per cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      o_valid <= 1'b0;
      o_last  <= 1'b0;
      o_x     <= '0;
      o_src   <= '0;
    end else if (accept) begin
      o_valid <= 1'b1;
      o_last  <= i_last[sel];
      o_x     <= i_x[sel];
      o_src   <= sel;
    end else if (i_ready) begin
      o_valid <= 1'b0;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_mux_arbiter.sv
`default_nettype none
// +-----------------------------------------------------------------+
// | tb_mux_arbiter: directed stimulus with a cycle model scoreboard |
// | Revision: 1.0                                                   |
// +-----------------------------------------------------------------+
module tb_mux_arbiter;

  localparam int W  = 8;
  localparam int N  = 4;
  localparam int TO = 16;

  logic         clk;
  logic         rst_n;
  logic [W-1:0] i_x [N];
  logic [N-1:0] i_valid;
  logic [N-1:0] i_last;
  logic [N-1:0] o_ready;
  logic [W-1:0] o_x;
  logic         o_valid;
  logic         o_last;
  logic [1:0]   o_src;
  logic         i_ready;
  logic         o_timeout;

  int n_cmp = 0;
  int n_bad = 0;

  mux_arbiter #(.WIDTH(W), .N_STATES(N), .TIMEOUT(TO)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .i_x       (i_x),
    .i_valid   (i_valid),
    .i_last    (i_last),
    .o_ready   (o_ready),
    .o_x       (o_x),
    .o_valid   (o_valid),
    .o_last    (o_last),
    .o_src     (o_src),
    .i_ready   (i_ready),
    .o_timeout (o_timeout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s actual=%0h required=%0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: packet-level arbitration rules applied once per cycle.
  bit         m_locked;
  int         m_owner, m_ptr, m_idle;
  bit         m_ov, m_ol, m_to;
  logic [W-1:0] m_ox;
  int         m_os;

  always @(negedge clk) begin
    if (!rst_n) begin
      m_locked = 0; m_owner = 0; m_ptr = 0; m_idle = 0;
      m_ov = 0; m_ol = 0; m_to = 0; m_ox = '0; m_os = 0;
      chk("m_rst_valid", {31'd0, o_valid}, 0);
      chk("m_rst_x", {24'd0, o_x}, 0);
      chk("m_rst_src", {30'd0, o_src}, 0);
    end else begin
      int  cand;
      bit  has, room, take;
      logic [N-1:0] exp_rdy;
      chk("m_valid", {31'd0, o_valid}, {31'd0, m_ov});
      chk("m_timeout", {31'd0, o_timeout}, {31'd0, m_to});
      if (m_ov) begin
        chk("m_x", {24'd0, o_x}, {24'd0, m_ox});
        chk("m_last", {31'd0, o_last}, {31'd0, m_ol});
        chk("m_src", {30'd0, o_src}, m_os);
      end
      cand = 0; has = 0;
      if (m_locked) begin
        cand = m_owner; has = i_valid[m_owner];
      end else begin
        for (int k = 0; k < N; k++)
          if (!has && i_valid[(m_ptr + k) % N]) begin
            has = 1; cand = (m_ptr + k) % N;
          end
      end
      room    = !m_ov || i_ready;
      take    = room && has;
      exp_rdy = take ? (N'(1) << cand) : '0;
      chk("m_ready", {28'd0, o_ready}, {28'd0, exp_rdy});
      m_to = 0;
      if (take) begin
        m_ov = 1; m_ox = i_x[cand]; m_ol = i_last[cand]; m_os = cand;
      end else if (i_ready) begin
        m_ov = 0;
      end
      if (m_locked) begin
        if (i_valid[m_owner]) begin
          m_idle = 0;
          if (take && i_last[m_owner]) begin
            m_locked = 0; m_ptr = (m_owner + 1) % N;
          end
        end else begin
          m_idle++;
          if (m_idle == TO) begin
            m_locked = 0; m_ptr = (m_owner + 1) % N; m_to = 1; m_idle = 0;
          end
        end
      end else if (take) begin
        if (i_last[cand]) m_ptr = (cand + 1) % N;
        else begin m_locked = 1; m_owner = cand; m_idle = 0; end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [W-1:0] fx [N];
    fx[0] = 8'h00; fx[1] = 8'hFF; fx[2] = 8'hAA; fx[3] = 8'h23;
    rst_n = 1'b0; i_valid = '0; i_last = '0; i_ready = 1'b1;
    for (int k = 0; k < N; k++) i_x[k] = '0;
    repeat (3) step();
    chk("rst_valid", {31'd0, o_valid}, 0);
    chk("rst_timeout", {31'd0, o_timeout}, 0);
    rst_n = 1'b1;

    // Single-beat fairness
    for (int k = 0; k < N; k++) i_x[k] = fx[k];
    i_valid = 4'hF; i_last = 4'hF;
    #1 chk("fair_rdy0", {28'd0, o_ready}, 32'h1);
    for (int i = 0; i < 8; i++) begin
      step();
      chk("fair_src", {30'd0, o_src}, i % 4);
      chk("fair_x", {24'd0, o_x}, {24'd0, fx[i % 4]});
    end
    i_valid = '0; i_last = '0;
    step();

    // Move pointer to 2 with a single beat from requester 1
    i_valid = 4'b0010; i_last = 4'b0010; i_x[1] = 8'h11;
    step();
    i_valid = '0; i_last = '0;

    // Packet lock on requester 2 while 0 and 1 compete
    i_valid = 4'b0111; i_last = 4'b0011;
    i_x[0] = 8'h01; i_x[1] = 8'h02; i_x[2] = 8'hAA;
    #1 chk("lock_rdy", {28'd0, o_ready}, 32'h4);
    step();
    chk("lock_b1_src", {30'd0, o_src}, 2); chk("lock_b1_x", {24'd0, o_x}, 32'hAA);
    chk("lock_b1_last", {31'd0, o_last}, 0);
    i_x[2] = 8'hAB;
    step();
    chk("lock_b2_src", {30'd0, o_src}, 2); chk("lock_b2_x", {24'd0, o_x}, 32'hAB);
    i_x[2] = 8'hAC; i_last = 4'b0111;
    step();
    chk("lock_b3_src", {30'd0, o_src}, 2); chk("lock_b3_x", {24'd0, o_x}, 32'hAC);
    chk("lock_b3_last", {31'd0, o_last}, 1);
    i_valid = 4'b0011; i_last = 4'b0011;
    #1 chk("lock_next_rdy", {28'd0, o_ready}, 32'h1);
    step();
    chk("lock_next_src", {30'd0, o_src}, 0); chk("lock_next_x", {24'd0, o_x}, 32'h01);
    i_valid = '0; i_last = '0;
    step();

    // Backpressure mid-packet on requester 1
    i_valid = 4'b0010; i_x[1] = 8'h10;
    step();
    chk("bp_b1", {24'd0, o_x}, 32'h10);
    i_x[1] = 8'h11;
    step();
    chk("bp_b2", {24'd0, o_x}, 32'h11);
    i_ready = 1'b0; i_x[1] = 8'h12;
    for (int i = 0; i < 5; i++) begin
      #1;
      chk("bp_hold_rdy", {28'd0, o_ready}, 0);
      chk("bp_hold_x", {24'd0, o_x}, 32'h11);
      chk("bp_hold_src", {30'd0, o_src}, 1);
      step();
    end
    chk("bp_hold_end", {24'd0, o_x}, 32'h11);
    i_ready = 1'b1;
    step();
    chk("bp_b3", {24'd0, o_x}, 32'h12);
    i_x[1] = 8'h13; i_last = 4'b0010;
    step();
    chk("bp_b4", {24'd0, o_x}, 32'h13); chk("bp_b4_last", {31'd0, o_last}, 1);
    i_valid = '0; i_last = '0;
    step();
    chk("bp_drained", {31'd0, o_valid}, 0);

    // Timeout: owner 1 stalls after its first beat
    i_valid = 4'b0010; i_x[1] = 8'h50;
    step();
    i_valid = 4'b0100; i_last = 4'b0100; i_x[2] = 8'h60;
    for (int i = 0; i < TO; i++) begin
      #1;
      chk("to_quiet", {31'd0, o_timeout}, 0);
      chk("to_ignored", {28'd0, o_ready}, 0);
      step();
    end
    #1;
    chk("to_pulse", {31'd0, o_timeout}, 1);
    chk("to_grant", {28'd0, o_ready}, 32'h4);
    step();
    chk("to_clear", {31'd0, o_timeout}, 0);
    chk("to_src", {30'd0, o_src}, 2); chk("to_x", {24'd0, o_x}, 32'h60);
    i_valid = '0; i_last = '0;
    step();

    // Asynchronous reset while locked on owner 3
    i_valid = 4'b1001; i_last = 4'b0001; i_x[3] = 8'h77; i_x[0] = 8'h05;
    step();
    chk("rr_src", {30'd0, o_src}, 3); chk("rr_valid", {31'd0, o_valid}, 1);
    i_ready = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    chk("rr_async_valid", {31'd0, o_valid}, 0);
    chk("rr_async_x", {24'd0, o_x}, 0);
    chk("rr_async_src", {30'd0, o_src}, 0);
    chk("rr_async_last", {31'd0, o_last}, 0);
    step();
    rst_n = 1'b1; i_ready = 1'b1;
    #1 chk("rr_first_rdy", {28'd0, o_ready}, 32'h1);
    step();
    chk("rr_first_src", {30'd0, o_src}, 0); chk("rr_first_x", {24'd0, o_x}, 32'h05);
    i_valid = '0; i_last = '0;

    // Single requester back-to-back
    i_valid = 4'b1000; i_last = 4'b1000;
    for (int i = 0; i < 6; i++) begin
      i_x[3] = 8'h30 + 8'(i);
      #1 chk("solo_rdy", {28'd0, o_ready}, 32'h8);
      step();
      chk("solo_valid", {31'd0, o_valid}, 1);
      chk("solo_src", {30'd0, o_src}, 3);
      chk("solo_x", {24'd0, o_x}, 32'h30 + i);
    end
    i_valid = '0; i_last = '0;
    step();
    step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
